// File: rtl/button_event_arbiter.sv
// Per-button PRESS/LONG/REPEAT/RELEASE generators feeding a round-robin valid/ready event register.
// Optional macro BUTTON_REPEAT_EN enables periodic REPEAT events while a button stays held after LONG.
module button_event_fsm #(
  parameter int LONG_TICKS = 500
`ifdef BUTTON_REPEAT_EN
  , parameter int REPEAT_TICKS = 100
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pressed_i,
  input  logic       tick_i,
  input  logic       grant_i,
  output logic       slot_vld_o,
  output logic [1:0] slot_type_o,
  output logic       ovr_o
);
  localparam logic [1:0] EV_PRESS = 2'd0, EV_LONG = 2'd1, EV_REPEAT = 2'd2, EV_RELEASE = 2'd3;

  typedef enum logic [1:0] {IDLE, HELD, AUTO} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        prev_q, slot_vld_q, slot_vld_d, gen;
  logic [1:0]  slot_type_q, slot_type_d, gen_type;
  logic        rise, fall;

  assign rise = pressed_i && !prev_q;
  assign fall = !pressed_i && prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prev_q      <= 1'b0;
      slot_vld_q  <= 1'b0;
      slot_type_q <= EV_PRESS;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_q      <= pressed_i;
      slot_vld_q  <= slot_vld_d;
      slot_type_q <= slot_type_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gen      = 1'b0;
    gen_type = EV_PRESS;
    case (state_q)
      IDLE: if (rise) begin
        gen = 1'b1; gen_type = EV_PRESS; cnt_d = '0; state_d = HELD;
      end
      HELD: begin
        if (fall) begin
          gen = 1'b1; gen_type = EV_RELEASE; state_d = IDLE;
        end else if (tick_i) begin
          if (cnt_q == 16'(LONG_TICKS - 1)) begin
            gen = 1'b1; gen_type = EV_LONG; cnt_d = '0; state_d = AUTO;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      AUTO: begin
        if (fall) begin
          gen = 1'b1; gen_type = EV_RELEASE; state_d = IDLE;
`ifdef BUTTON_REPEAT_EN
        end else if (tick_i) begin
          if (cnt_q == 16'(REPEAT_TICKS - 1)) begin
            gen = 1'b1; gen_type = EV_REPEAT; cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new event lands in the slot even while the old one is granted, so nothing is lost then.
  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_type_d = slot_type_q;
    ovr_o       = gen && slot_vld_q && !grant_i;
    if (gen) begin
      slot_vld_d  = 1'b1;
      slot_type_d = gen_type;
    end else if (grant_i) begin
      slot_vld_d  = 1'b0;
    end
  end

  assign slot_vld_o  = slot_vld_q;
  assign slot_type_o = slot_type_q;
endmodule

module button_event_arbiter #(
  parameter int NUM_BUTTONS  = 4,
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  localparam int IW = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] btn_pressed,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [IW-1:0]          evt_btn,
  output logic [1:0]             evt_type,
  output logic                   overrun
);
  localparam int PW = $clog2(TICK_DIV);

  if (NUM_BUTTONS < 1 || NUM_BUTTONS > 16 || TICK_DIV < 2 || LONG_TICKS < 1 || LONG_TICKS > 65535 ||
      REPEAT_TICKS < 1 || REPEAT_TICKS > 65535) begin : g_bad_params
    $error("button_event_arbiter: parameter out of range");
  end

  logic [PW-1:0]                    pre_q;
  logic                             tick;
  logic [NUM_BUTTONS-1:0]           slot_vld, grant, ovr;
  logic [NUM_BUTTONS-1:0][1:0]      slot_type;
  logic [IW-1:0]                    last_q, gidx, cand, evt_btn_q;
  logic [1:0]                       evt_type_q;
  logic                             evt_valid_q, overrun_q, found, load;

  assign tick = (pre_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= tick ? '0 : pre_q + PW'(1);
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_lane
    assign grant[i] = load && found && (gidx == IW'(i));
    button_event_fsm #(
      .LONG_TICKS(LONG_TICKS)
`ifdef BUTTON_REPEAT_EN
      , .REPEAT_TICKS(REPEAT_TICKS)
`endif
    ) u_lane (
      .clk(clk), .rst(rst), .pressed_i(btn_pressed[i]), .tick_i(tick), .grant_i(grant[i]),
      .slot_vld_o(slot_vld[i]), .slot_type_o(slot_type[i]), .ovr_o(ovr[i])
    );
  end

  // Search starts one past the last winner so every button gets a turn.
  assign load = !evt_valid_q || evt_ready;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_BUTTONS; k++) begin
      cand = IW'((int'(last_q) + k) % NUM_BUTTONS);
      if (!found && slot_vld[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid_q <= 1'b0;
      evt_btn_q   <= '0;
      evt_type_q  <= 2'd0;
      last_q      <= IW'(NUM_BUTTONS - 1);
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= overrun_q | (|ovr);
      if (load) begin
        evt_valid_q <= found;
        if (found) begin
          evt_btn_q  <= gidx;
          evt_type_q <= slot_type[gidx];
          last_q     <= gidx;
        end
      end
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_btn   = evt_btn_q;
  assign evt_type  = evt_type_q;
  assign overrun   = overrun_q;
endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Turns the debounced `pressed` levels of up to `NUM_BUTTONS` Button instances into a single stream of typed UI events: PRESS, LONG, REPEAT and RELEASE. Each button has its own hold-timer state machine, and each button can hold one pending event. A round-robin arbiter moves pending events into one valid/ready output register. The block sits between the Button debouncers and the UI/menu logic, so consumers never have to poll per-button levels.

## Interface
- `NUM_BUTTONS`, default 4: number of button inputs, 1..16.
- `TICK_DIV`, default 50000: clk cycles per timing tick (1 ms at 50 MHz), ≥2.
- `LONG_TICKS`, default 500: ticks from press until LONG, 1..65535.
- `REPEAT_TICKS`, default 100: ticks between REPEAT events after LONG, 1..65535.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `btn_pressed`  in  `NUM_BUTTONS`: debounced level per button, synchronous to `clk`.
- `evt_valid`  out  1: an event is presented on the output.
- `evt_ready`  in  1: the consumer accepts the event.
- `evt_btn`  out  `$clog2(NUM_BUTTONS)` (min 1): index of the source button.
- `evt_type`  out  2: 0=PRESS, 1=LONG, 2=REPEAT, 3=RELEASE.
- `overrun`  out  1: sticky flag, set when a pending event was overwritten. Cleared only by `rst`.

## Operation
- Prescaler: free-running counter from 0 to `TICK_DIV-1`. `tick` pulses for 1 cycle on wrap. The prescaler is never restarted by button activity.
- Per-button state, with registered `prev = btn_pressed[i]`:
  - IDLE: on a rising edge (`btn_pressed=1`, `prev=0`), generate PRESS, clear the 16-bit hold counter, go to HELD.
  - HELD: on each `tick`, increment the counter. When it reaches `LONG_TICKS`, generate LONG, clear the counter, go to AUTO.
  - AUTO: on each `tick`, increment the counter. When it reaches `REPEAT_TICKS`, generate REPEAT and clear the counter (only with `BUTTON_REPEAT_EN`).
  - From HELD or AUTO: on a falling edge, generate RELEASE and go to IDLE. A falling edge overrides a tick in the same cycle.
- Pending slot per button: holds a valid bit and a 2-bit type.
  - A generated event writes the slot.
  - If the slot is already valid and is not being granted this cycle, the new event overwrites it and `overrun` is set.
  - If the slot is granted and a new event is generated in the same cycle, the new event stays pending and no overrun is raised.
- Arbiter:
  - The output register loads when `!evt_valid || evt_ready`.
  - It grants the first valid slot searching upward from `last+1`, wrapping modulo `NUM_BUTTONS`.
  - `last` updates to the granted index. Its reset value is `NUM_BUTTONS-1`, so button 0 has priority first.
  - The grant clears the slot and loads `evt_btn`/`evt_type`.
  - `evt_valid` deasserts only when `evt_ready=1` and no slot is valid.
- Output stability: while `evt_valid=1` and `evt_ready=0`, `evt_btn` and `evt_type` must not change.
- Reset values: `evt_valid=0`, `evt_btn=0`, `evt_type=0`, `overrun=0`. Additionally all slots are empty, all states are IDLE, all `prev=0`, and the prescaler is 0.
- Reset mid-operation: the async assert clears everything immediately, including an unaccepted event. A button held through reset sees a rising edge after reset release and produces PRESS.

## Timing
- Edge detection: `btn_pressed` rises at edge t, the slot is valid after edge t+1, and `evt_valid=1` after edge t+2 if the output register is free and the button wins arbitration.
- LONG is generated on the `LONG_TICKS`-th tick after the press edge. The first tick may be partial, so the delay is (`LONG_TICKS-1`)·`TICK_DIV`+1 to `LONG_TICKS`·`TICK_DIV` cycles.
- Throughput: 1 event per cycle while `evt_ready=1` and slots are pending.
- `evt_ready` is sampled only when `evt_valid=1`. There is no combinational path from `evt_ready` to `evt_valid`.

## Configuration
- `BUTTON_REPEAT_EN`:
  - Defined: AUTO emits REPEAT every `REPEAT_TICKS` ticks while the button is held.
  - Undefined: AUTO only waits for the release. No REPEAT event is ever produced and the AUTO counter logic is not synthesized. Type code 2 is then never output.

## Test plan
Bench parameters for all scenarios: `NUM_BUTTONS=4`, `TICK_DIV=4`, `LONG_TICKS=3`, `REPEAT_TICKS=2`.

- Short press: `btn_pressed[0]` held for 2 ticks then released, `evt_ready=1` -> exactly PRESS(0) then RELEASE(0). No LONG, `overrun=0`.
- Long hold: `btn_pressed[1]` held for 10 ticks, `BUTTON_REPEAT_EN` defined -> PRESS(1), LONG(1) at tick 3, REPEAT(1) at ticks 5, 7 and 9, then RELEASE(1). With the macro undefined -> PRESS, LONG, RELEASE only.
- Simultaneous press: buttons 0, 2 and 3 rise on the same cycle, `evt_ready=1` -> PRESS 0, 2, 3 on 3 consecutive cycles. Next, buttons 0 and 3 rise together -> PRESS 0 then PRESS 3, with round-robin continuing from index 3.
- Backpressure: `evt_ready=0`; button 0 presses, releases, presses -> PRESS(0) is held stable on the output and RELEASE is overwritten by PRESS, so `overrun=1`. Raising `evt_ready` -> PRESS(0) then PRESS(0), after which `evt_valid=0`.
- Reset mid-operation: `rst` pulses while `evt_valid=1` and button 2 is held -> outputs go to 0 asynchronously and `overrun=0`. After release, PRESS(2) appears 2 cycles after the first post-reset edge that samples `btn_pressed=1`.
